// File: rtl/vec_processor_pkg.sv
// Shared types for the vector processor: opcodes, FSM states, register
// indices and the vector-width helper used by the top and the lane ALU.
package vec_processor_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_MUL   = 3'b011,
    OP_SET   = 3'b100,
    OP_GET   = 3'b101
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM,
    ST_MWAIT,
    ST_EXEC,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] REG_A1 = 2'd0;
  localparam logic [1:0] REG_A2 = 2'd1;
  localparam logic [1:0] REG_A3 = 2'd2;
  localparam logic [1:0] REG_A4 = 2'd3;

  function automatic int vecWidth(input int lanes, input int laneW);
    return lanes * laneW;
  endfunction

endpackage

// File: rtl/vec_processor_lane_alu.sv
// Lane-wise arithmetic for the vector processor. The add result is registered
// once and the multiply runs through a MUL_CYC-deep pipeline, both free-running.
module vec_lane_alu
  import vec_processor_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int LANE_W  = 32,
  parameter int MUL_CYC = 2,
  localparam int VEC_W  = vecWidth(LANES, LANE_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_mul_i,
  input  logic [VEC_W-1:0] a_i,
  input  logic [VEC_W-1:0] b_i,
  output logic [VEC_W-1:0] lo_o,
  output logic [VEC_W-1:0] hi_o
);

  localparam int PROD_W = 2 * LANE_W;

  logic [VEC_W-1:0]        sumLo;
  logic [VEC_W-1:0]        sumHi;
  logic [LANES*PROD_W-1:0] prod;
  logic [VEC_W-1:0]        addLo_q;
  logic [VEC_W-1:0]        addHi_q;
  logic [LANES*PROD_W-1:0] mulPipe_q [MUL_CYC];
  logic [VEC_W-1:0]        mulLo;
  logic [VEC_W-1:0]        mulHi;

  // Carry of each lane lands in bit 0 of its hi lane; the rest stays zero.
  always_comb begin
    sumLo = '0;
    sumHi = '0;
    prod  = '0;
    for (int l = 0; l < LANES; l++) begin
      {sumHi[l*LANE_W], sumLo[l*LANE_W +: LANE_W]} =
        {1'b0, a_i[l*LANE_W +: LANE_W]} + {1'b0, b_i[l*LANE_W +: LANE_W]};
      prod[l*PROD_W +: PROD_W] =
        {{LANE_W{1'b0}}, a_i[l*LANE_W +: LANE_W]} *
        {{LANE_W{1'b0}}, b_i[l*LANE_W +: LANE_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addLo_q <= '0;
      addHi_q <= '0;
      for (int s = 0; s < MUL_CYC; s++) begin
        mulPipe_q[s] <= '0;
      end
    end else begin
      addLo_q      <= sumLo;
      addHi_q      <= sumHi;
      mulPipe_q[0] <= prod;
      for (int s = 1; s < MUL_CYC; s++) begin
        mulPipe_q[s] <= mulPipe_q[s-1];
      end
    end
  end

  always_comb begin
    mulLo = '0;
    mulHi = '0;
    for (int l = 0; l < LANES; l++) begin
      mulLo[l*LANE_W +: LANE_W] = mulPipe_q[MUL_CYC-1][l*PROD_W +: LANE_W];
      mulHi[l*LANE_W +: LANE_W] = mulPipe_q[MUL_CYC-1][l*PROD_W + LANE_W +: LANE_W];
    end
  end

  assign lo_o = is_mul_i ? mulLo : addLo_q;
  assign hi_o = is_mul_i ? mulHi : addHi_q;

endmodule

// File: rtl/vec_processor.sv
// Four-register vector processor: one command at a time over valid/ready,
// executed by a multi-cycle FSM that drives the external vector memory port.
module vec_processor
  import vec_processor_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int LANE_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int MUL_CYC = 2,
  localparam int VEC_W  = vecWidth(LANES, LANE_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [VEC_W-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [VEC_W-1:0]  rsp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [VEC_W-1:0]  mem_wdata,
  input  logic [VEC_W-1:0]  mem_rdata
);

  localparam int CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  state_t              state_q;
  logic [2:0]          op_q;
  logic [1:0]          reg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [VEC_W-1:0]    regs_q [4];
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [VEC_W-1:0]    rsp_data_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [VEC_W-1:0]    mem_wdata_q;
  logic [VEC_W-1:0]    aluLo;
  logic [VEC_W-1:0]    aluHi;

  vec_lane_alu #(
    .LANES   (LANES),
    .LANE_W  (LANE_W),
    .MUL_CYC (MUL_CYC)
  ) u_alu (
    .clk      (clk),
    .reset    (reset),
    .is_mul_i (op_q == OP_MUL),
    .a_i      (regs_q[REG_A1]),
    .b_i      (regs_q[REG_A2]),
    .lo_o     (aluLo),
    .hi_o     (aluHi)
  );

  assign cmd_ready = (state_q == ST_IDLE) && reset;

  // Response and memory strobes default low each cycle so they pulse for one
  // cycle; the ALU pipelines sample A1/A2 on the handshake edge already.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      reg_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int r = 0; r < 4; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            reg_q <= cmd_reg;
            case (cmd_op)
              OP_LOAD, OP_STORE: begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= (cmd_op == OP_STORE);
                mem_addr_q  <= cmd_addr;
                mem_wdata_q <= (cmd_op == OP_STORE) ? regs_q[cmd_reg] : '0;
                state_q     <= ST_MEM;
              end
              OP_ADD: begin
                cnt_q   <= '0;
                state_q <= ST_EXEC;
              end
              OP_MUL: begin
                cnt_q   <= CNT_W'(MUL_CYC - 1);
                state_q <= ST_EXEC;
              end
              OP_SET: begin
                regs_q[cmd_reg] <= cmd_data;
                rsp_valid_q     <= 1'b1;
                state_q         <= ST_DONE;
              end
              OP_GET: begin
                rsp_data_q  <= regs_q[cmd_reg];
                rsp_valid_q <= 1'b1;
                state_q     <= ST_DONE;
              end
              default: begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                state_q     <= ST_ERR;
              end
            endcase
          end
        end
        ST_MEM: begin
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          if (op_q == OP_LOAD) begin
            state_q <= ST_MWAIT;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_MWAIT: begin
          regs_q[reg_q] <= mem_rdata;
          rsp_valid_q   <= 1'b1;
          state_q       <= ST_DONE;
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            regs_q[REG_A3] <= aluLo;
            regs_q[REG_A4] <= aluHi;
            rsp_valid_q    <= 1'b1;
            state_q        <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE, ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vec_processor.sv
// Randomized bench for vec_processor against a lane-level reference model,
// with directed reset, ADD/MUL boundary, LOAD/STORE, illegal and abort cases.
module tb_vec_processor;
  import vec_processor_pkg::*;

  localparam int LANES   = 16;
  localparam int LANE_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int MUL_CYC = 2;
  localparam int VEC_W   = LANES * LANE_W;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [1:0]        cmd_reg;
  logic [ADDR_W-1:0] cmd_addr;
  logic [VEC_W-1:0]  cmd_data;
  logic              rsp_valid;
  logic              rsp_err;
  logic [VEC_W-1:0]  rsp_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [VEC_W-1:0]  mem_wdata;
  logic [VEC_W-1:0]  mem_rdata;

  vec_processor #(
    .LANES   (LANES),
    .LANE_W  (LANE_W),
    .ADDR_W  (ADDR_W),
    .MUL_CYC (MUL_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_reg   (cmd_reg),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: registers and memory image, plus the latest response.
  logic [VEC_W-1:0] mReg [4];
  logic [VEC_W-1:0] mMem [DEPTH];
  bit               mWritten [DEPTH];
  logic [VEC_W-1:0] lastRspData;

  // External memory: untouched words read back a fixed per-address pattern.
  logic [VEC_W-1:0] extMem [DEPTH];
  bit               extWritten [DEPTH];

  function automatic logic [VEC_W-1:0] initWord(input int addr);
    logic [VEC_W-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      if (addr == DEPTH - 1) w[l*LANE_W +: LANE_W] = LANE_W'(l);
      else w[l*LANE_W +: LANE_W] = LANE_W'(addr * 32'h9E3779B1 + l * 32'h85EBCA6B);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      extMem[mem_addr]     <= mem_wdata;
      extWritten[mem_addr] <= 1'b1;
    end
    if (mem_req && !mem_we) begin
      mem_rdata <= extWritten[mem_addr] ? extMem[mem_addr] : initWord(int'(mem_addr));
    end
  end

  function automatic logic [VEC_W-1:0] laneFill(input logic [LANE_W-1:0] v);
    logic [VEC_W-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*LANE_W +: LANE_W] = v;
    return w;
  endfunction

  function automatic logic [VEC_W-1:0] randVec();
    logic [VEC_W-1:0] w;
    for (int l = 0; l < LANES; l++) begin
      if ($urandom_range(0, 3) == 0) w[l*LANE_W +: LANE_W] = '1;
      else w[l*LANE_W +: LANE_W] = LANE_W'($urandom);
    end
    return w;
  endfunction

  function automatic int expLatency(input logic [2:0] op);
    case (op)
      3'b000:  return 3;
      3'b001:  return 2;
      3'b010:  return 2;
      3'b011:  return 1 + MUL_CYC;
      default: return 1;
    endcase
  endfunction

  function automatic logic [VEC_W-1:0] memRead(input int addr);
    return mWritten[addr] ? mMem[addr] : initWord(addr);
  endfunction

  // Lane arithmetic by plain integer division into low part and high part.
  task automatic modelArith(input bit isMul);
    longint unsigned a, b, r, base;
    logic [63:0] lo, hi;
    base = 64'd1 << LANE_W;
    for (int l = 0; l < LANES; l++) begin
      a = 64'(mReg[0][l*LANE_W +: LANE_W]);
      b = 64'(mReg[1][l*LANE_W +: LANE_W]);
      r = isMul ? a * b : a + b;
      lo = r % base;
      hi = r / base;
      mReg[2][l*LANE_W +: LANE_W] = lo[LANE_W-1:0];
      mReg[3][l*LANE_W +: LANE_W] = hi[LANE_W-1:0];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [VEC_W-1:0] actual,
                             input logic [VEC_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Issues one command from a negedge, follows it to its response and the
  // following cycle, and checks timing, response and memory traffic.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rsel,
                               input logic [ADDR_W-1:0] addr,
                               input logic [VEC_W-1:0] data, input string tag);
    int               waitCnt, lat, memCnt, memCyc;
    bit               gotRsp, idleBad, isMem;
    logic             memWeSeen, rspErr;
    logic [ADDR_W-1:0] memAddrSeen;
    logic [VEC_W-1:0] memWdSeen, rspData, expData, expWd;
    waitCnt = 0; lat = -1; memCnt = 0; memCyc = -1;
    gotRsp = 0; idleBad = 0; memWeSeen = 0; memAddrSeen = '0; memWdSeen = '0;
    rspErr = 0; rspData = '0;
    isMem   = (op == OP_LOAD) || (op == OP_STORE);
    expData = (op == OP_GET) ? mReg[rsel] : '0;
    expWd   = (op == OP_STORE) ? mReg[rsel] : '0;

    while (!cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmd_ready) begin
      checkOutput({tag, "_readyTimeout"}, VEC_W'(cmd_ready), VEC_W'(1));
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rsel;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = '0;

    for (int k = 1; k <= 20 && !gotRsp; k++) begin
      @(negedge clk);
      if (mem_req) begin
        memCnt++;
        memCyc      = k;
        memWeSeen   = mem_we;
        memAddrSeen = mem_addr;
        memWdSeen   = mem_wdata;
      end else if (mem_we || (mem_addr != '0) || (mem_wdata != '0)) begin
        idleBad = 1;
      end
      if (rsp_valid) begin
        gotRsp  = 1;
        lat     = k;
        rspErr  = rsp_err;
        rspData = rsp_data;
      end
    end
    checkOutput({tag, "_rsp"}, VEC_W'(gotRsp), VEC_W'(1));
    if (!gotRsp) return;
    lastRspData = rspData;
    checkOutput({tag, "_latency"}, VEC_W'(lat), VEC_W'(expLatency(op)));
    checkOutput({tag, "_err"}, VEC_W'(rspErr), VEC_W'(op[2] && op[1]));
    checkOutput({tag, "_data"}, rspData, expData);
    checkOutput({tag, "_memIdleZero"}, VEC_W'(idleBad), VEC_W'(0));
    checkOutput({tag, "_memReqCount"}, VEC_W'(memCnt), VEC_W'(isMem ? 1 : 0));
    if (isMem) begin
      checkOutput({tag, "_memReqCycle"}, VEC_W'(memCyc), VEC_W'(1));
      checkOutput({tag, "_memAddr"}, VEC_W'(memAddrSeen), VEC_W'(addr));
      checkOutput({tag, "_memWe"}, VEC_W'(memWeSeen), VEC_W'(op == OP_STORE));
      checkOutput({tag, "_memWdata"}, memWdSeen, expWd);
    end

    case (op)
      OP_LOAD:  mReg[rsel] = memRead(int'(addr));
      OP_STORE: begin
        mMem[addr]     = mReg[rsel];
        mWritten[addr] = 1'b1;
      end
      OP_ADD:   modelArith(1'b0);
      OP_MUL:   modelArith(1'b1);
      OP_SET:   mReg[rsel] = data;
      default:  ;
    endcase

    @(negedge clk);
    checkOutput({tag, "_after"}, VEC_W'({rsp_valid, cmd_ready}), VEC_W'(2'b01));
  endtask

  task automatic getAll(input string tag);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(OP_GET, 2'(r), '0, '0, $sformatf("%s_getA%0d", tag, r + 1));
    end
  endtask

  logic [VEC_W-1:0] pattern;
  bit               rspSeen;

  initial begin
    for (int r = 0; r < 4; r++) mReg[r] = '0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_reg   = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    lastRspData = '0;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outputs",
                  VEC_W'({cmd_ready, rsp_valid, rsp_err, mem_req, mem_we,
                          |mem_addr, |mem_wdata, |rsp_data}), VEC_W'(0));
    end
    reset = 1'b1;
    #1;
    checkOutput("ready_after_reset", VEC_W'(cmd_ready), VEC_W'(1));
    getAll("reset");

    $display("[TB] ADD carry boundary");
    applyStimulus(OP_SET, REG_A1, '0, laneFill('1), "add_setA1");
    applyStimulus(OP_SET, REG_A2, '0, laneFill(32'h1), "add_setA2");
    applyStimulus(OP_ADD, 2'd0, '0, '0, "add");
    applyStimulus(OP_GET, REG_A3, '0, '0, "add_getA3");
    checkOutput("add_A3_const", lastRspData, '0);
    applyStimulus(OP_GET, REG_A4, '0, '0, "add_getA4");
    checkOutput("add_A4_const", lastRspData, laneFill(32'h1));

    $display("[TB] MUL max operands");
    applyStimulus(OP_SET, REG_A2, '0, laneFill('1), "mul_setA2");
    applyStimulus(OP_MUL, 2'd0, '0, '0, "mul");
    applyStimulus(OP_GET, REG_A3, '0, '0, "mul_getA3");
    checkOutput("mul_A3_const", lastRspData, laneFill(32'h1));
    applyStimulus(OP_GET, REG_A4, '0, '0, "mul_getA4");
    checkOutput("mul_A4_const", lastRspData, laneFill(32'hFFFFFFFE));

    $display("[TB] LOAD/STORE at address extremes");
    for (int l = 0; l < LANES; l++) pattern[l*LANE_W +: LANE_W] = LANE_W'(l);
    applyStimulus(OP_LOAD, REG_A2, 9'h1FF, '0, "load");
    applyStimulus(OP_GET, REG_A2, '0, '0, "load_getA2");
    checkOutput("load_A2_const", lastRspData, pattern);
    applyStimulus(OP_STORE, REG_A2, 9'h000, '0, "store");
    checkOutput("store_mem0", extMem[0], pattern);

    $display("[TB] illegal opcode");
    applyStimulus(3'b111, REG_A1, '0, randVec(), "illegal");
    getAll("illegal");

    $display("[TB] random commands");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    ADDR_W'($urandom), randVec(), $sformatf("rand%0d", i));
    end
    getAll("final");

    $display("[TB] reset during MUL");
    applyStimulus(OP_SET, REG_A1, '0, randVec(), "abort_setA1");
    applyStimulus(OP_SET, REG_A2, '0, randVec(), "abort_setA2");
    rspSeen   = 0;
    cmd_valid = 1'b1;
    cmd_op    = OP_MUL;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rspSeen |= rsp_valid;
    reset = 1'b0;
    @(negedge clk);
    rspSeen |= rsp_valid;
    checkOutput("abort_ready_low", VEC_W'(cmd_ready), VEC_W'(0));
    reset = 1'b1;
    #1;
    checkOutput("abort_idle", VEC_W'(cmd_ready), VEC_W'(1));
    repeat (6) begin
      @(negedge clk);
      rspSeen |= rsp_valid;
    end
    checkOutput("abort_no_rsp", VEC_W'(rspSeen), VEC_W'(0));
    for (int r = 0; r < 4; r++) mReg[r] = '0;
    getAll("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
